// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg: shared UART definitions (receiver states, default frame/oversample
// sizes, baud-divider helper used by the baud generator and transmitter).
package uart_rx_os_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE_DEF);
  endfunction
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: receiver bus; baud_tick/rx in, rx_data/rx_done/rx_busy/frame_err out.
// slave = receiver side, master = the side driving the line and ticks.
interface uart_rx_os_if import uart_rx_os_pkg::*; #(parameter int DATA_BITS = DATA_BITS_DEF);
  logic baud_tick;
  logic rx;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_done;
  logic rx_busy;
  logic frame_err;
  modport master(output baud_tick, rx, input rx_data, rx_done, rx_busy, frame_err);
  modport slave(input baud_tick, rx, output rx_data, rx_done, rx_busy, frame_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop synchronizer for an async input.
// Ports: clk, rst (async, active-high), d (async in), q (synchronized out, RST_VAL in reset).
module sync_2ff #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver, 16x oversampled, mid-bit sampling, glitch/framing checks.
// Ports: clk, rst (async, active-high), bus (uart_rx_os_if.slave: baud_tick, rx in;
// rx_data, rx_done pulse, rx_busy, frame_err pulse out).
module uart_rx_os import uart_rx_os_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input logic clk,
  input logic rst,
  uart_rx_os_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic rx_s, done_n, ferr_n;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_s));
  assign bus.rx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    bit_n = bit_cnt;
    shift_n = shift_reg;
    done_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        tick_n = '0;
        state_n = START;
      end
      START: if (bus.baud_tick) begin
        if (tick_cnt == HALF) begin
          tick_n = '0;
          bit_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end else tick_n = tick_cnt + 1'b1;
      end
      DATA: if (bus.baud_tick) begin
        if (tick_cnt == LAST) begin
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          tick_n = '0;
          if (bit_cnt == BLAST) state_n = STOP;
          else bit_n = bit_cnt + 1'b1;
        end else tick_n = tick_cnt + 1'b1;
      end
      STOP: if (bus.baud_tick) begin
        if (tick_cnt == LAST) begin
          tick_n = '0;
          done_n = rx_s;
          ferr_n = !rx_s;
          state_n = rx_s ? IDLE : BREAK;
        end else tick_n = tick_cnt + 1'b1;
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      bus.rx_data <= '0;
      bus.rx_done <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= state_n;
      tick_cnt <= tick_n;
      bit_cnt <= bit_n;
      shift_reg <= shift_n;
      bus.rx_done <= done_n;
      bus.frame_err <= ferr_n;
      if (done_n) bus.rx_data <= shift_reg;
    end
endmodule
